// File: rtl/mem_port_arbiter_if.sv
// Bus bundle joining the rv32i fetch and load/store requesters, the port arbiter and the shared memory.
// The arbiter takes the slave view; the core and memory side take the master view.
interface mem_port_arbiter_if;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;

    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_resp_valid, if_resp_data,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_resp_valid, if_resp_data,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, one transaction at a time,
// with data priority limited by a streak counter and a watchdog that answers for a silent memory.
module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              timeout_err
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] WD_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [SW-1:0] streak;
    logic [TW-1:0] wd_count;
    logic          owner_data;
    logic          grant_d;
    logic          grant_f;
    logic          resp_ok;
    logic          resp_to;
    logic [31:0]   resp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Fetch only wins a contended IDLE cycle once data has used up its streak.
    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_f    = 1'b0;
        resp_ok    = 1'b0;
        resp_to    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.d_req_valid && (!bus.if_req_valid || streak != STREAK_MAX)) begin
                    grant_d = 1'b1;
                end else if (bus.if_req_valid) begin
                    grant_f = 1'b1;
                end
                if (grant_d || grant_f) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.mem_req_ready) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    resp_ok    = 1'b1;
                    next_state = S_IDLE;
                end else if (TIMEOUT > 0 && wd_count == WD_LAST) begin
                    resp_to    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign bus.if_req_ready  = grant_f;
    assign bus.d_req_ready   = grant_d;
    assign bus.mem_req_valid = (state == S_ISSUE);
    assign busy              = (state != S_IDLE);
    assign resp_data         = (resp_ok && !bus.mem_we) ? bus.mem_rdata : 32'h0;

    // Stores and watchdog aborts report zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak            <= '0;
            wd_count          <= '0;
            owner_data        <= 1'b0;
            bus.mem_addr      <= 32'h0;
            bus.mem_we        <= 1'b0;
            bus.mem_wdata     <= 32'h0;
            bus.mem_wstrb     <= 4'h0;
            bus.if_resp_valid <= 1'b0;
            bus.if_resp_data  <= 32'h0;
            bus.d_resp_valid  <= 1'b0;
            bus.d_resp_data   <= 32'h0;
            timeout_err       <= 1'b0;
        end else begin
            bus.if_resp_valid <= 1'b0;
            bus.d_resp_valid  <= 1'b0;

            if (grant_d) begin
                owner_data    <= 1'b1;
                bus.mem_addr  <= bus.d_req_addr;
                bus.mem_we    <= bus.d_req_we;
                bus.mem_wdata <= bus.d_req_we ? bus.d_req_wdata : 32'h0;
                bus.mem_wstrb <= bus.d_req_we ? bus.d_req_wstrb : 4'h0;
                if (bus.if_req_valid && streak != STREAK_MAX) begin
                    streak <= streak + SW'(1);
                end
            end

            if (grant_f) begin
                owner_data    <= 1'b0;
                bus.mem_addr  <= bus.if_req_addr;
                bus.mem_we    <= 1'b0;
                bus.mem_wdata <= 32'h0;
                bus.mem_wstrb <= 4'h0;
                streak        <= '0;
            end

            if (state == S_ISSUE && bus.mem_req_ready) begin
                wd_count <= '0;
            end else if (state == S_WAIT) begin
                wd_count <= wd_count + TW'(1);
            end

            if (resp_ok || resp_to) begin
                if (owner_data) begin
                    bus.d_resp_valid <= 1'b1;
                    bus.d_resp_data  <= resp_data;
                end else begin
                    bus.if_resp_valid <= 1'b1;
                    bus.if_resp_data  <= resp_data;
                end
            end

            if (resp_to) begin
                timeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus hand-written
// sequences for arbitration fairness, watchdog expiry, reset during WAIT and a last-cycle response.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic timeout_err;
    int   checks   = 0;
    int   failures = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MAX_DATA_STREAK(4),
        .TIMEOUT        (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ready_delay;
        int          rvalid_delay;
        logic [31:0] rdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic clear_inputs();
        bus.if_req_valid  = 1'b0;
        bus.if_req_addr   = 32'h0;
        bus.d_req_valid   = 1'b0;
        bus.d_req_we      = 1'b0;
        bus.d_req_addr    = 32'h0;
        bus.d_req_wdata   = 32'h0;
        bus.d_req_wstrb   = 4'h0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check_output($sformatf("%s_busy", tag), busy, 0);
        check_output($sformatf("%s_timeout_err", tag), timeout_err, 0);
        check_output($sformatf("%s_mem_req_valid", tag), bus.mem_req_valid, 0);
        check_output($sformatf("%s_mem_addr", tag), bus.mem_addr, 0);
        check_output($sformatf("%s_mem_we_wstrb", tag), {27'd0, bus.mem_we, bus.mem_wstrb}, 0);
        check_output($sformatf("%s_mem_wdata", tag), bus.mem_wdata, 0);
        check_output($sformatf("%s_resp_valids", tag), {30'd0, bus.d_resp_valid, bus.if_resp_valid}, 0);
        check_output($sformatf("%s_if_resp_data", tag), bus.if_resp_data, 0);
        check_output($sformatf("%s_d_resp_data", tag), bus.d_resp_data, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_mem_fields(input vec_t v, input string tag);
        logic is_store;
        is_store = v.is_data && v.we;
        check_output($sformatf("%s_mem_req_valid", tag), bus.mem_req_valid, 1);
        check_output($sformatf("%s_mem_addr", tag), bus.mem_addr, v.addr);
        check_output($sformatf("%s_mem_we", tag), bus.mem_we, is_store);
        check_output($sformatf("%s_mem_wstrb", tag), bus.mem_wstrb, is_store ? v.wstrb : 4'h0);
        if (is_store) begin
            check_output($sformatf("%s_mem_wdata", tag), bus.mem_wdata, v.wdata);
        end
    endtask

    // One complete transaction from an IDLE arbiter with a single requester.
    task automatic apply_stimulus(input vec_t v, input string tag);
        @(negedge clk);
        if (v.is_data) begin
            bus.d_req_valid = 1'b1;
            bus.d_req_we    = v.we;
            bus.d_req_addr  = v.addr;
            bus.d_req_wdata = v.wdata;
            bus.d_req_wstrb = v.wstrb;
        end else begin
            bus.if_req_valid = 1'b1;
            bus.if_req_addr  = v.addr;
        end
        #1;
        check_output($sformatf("%s_ready", tag), {30'd0, bus.d_req_ready, bus.if_req_ready},
                     v.is_data ? 32'd2 : 32'd1);
        @(negedge clk);
        bus.if_req_valid = 1'b0;
        bus.d_req_valid  = 1'b0;
        #1;
        check_mem_fields(v, tag);
        for (int i = 0; i < v.ready_delay; i++) begin
            @(negedge clk);
            #1;
            check_mem_fields(v, $sformatf("%s_hold%0d", tag, i));
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        #1;
        check_output($sformatf("%s_wait_req_valid", tag), bus.mem_req_valid, 0);
        check_output($sformatf("%s_wait_busy", tag), busy, 1);
        repeat (v.rvalid_delay) @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = v.rdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        check_output($sformatf("%s_resp_valids", tag), {30'd0, bus.d_resp_valid, bus.if_resp_valid},
                     v.is_data ? 32'd2 : 32'd1);
        check_output($sformatf("%s_resp_data", tag), v.is_data ? bus.d_resp_data : bus.if_resp_data, v.exp_data);
        check_output($sformatf("%s_idle_busy", tag), busy, 0);
        @(negedge clk);
        #1;
        check_output($sformatf("%s_resp_pulse_end", tag), {30'd0, bus.d_resp_valid, bus.if_resp_valid}, 0);
    endtask

    initial begin
        bit   exp_d[10];
        int   cycles;
        vec_t fetch_after;
        vec_t load_after;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'h0050_0093, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'b0011, 3, 0, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0204, 32'h1234_5678, 4'hF, 1, 2, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 2, 3, 32'h1234_5678, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        exp_d       = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        fetch_after = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 1, 32'h0000_0013, 32'h0000_0013};
        load_after  = '{1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'h0, 0, 0, 32'h7777_0001, 32'h7777_0001};

        do_reset();

        for (int n = 0; n < 5; n++) begin
            apply_stimulus(vecs[n], $sformatf("vec%0d", n));
        end
        check_output("hold_if_resp_data", bus.if_resp_data, 32'h1234_5678);
        check_output("hold_d_resp_data", bus.d_resp_data, 32'hFFFF_FFFF);

        // Both requesters valid on every IDLE cycle.
        do_reset();
        bus.mem_rdata    = 32'h1111_2222;
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h0000_0040;
        bus.d_req_valid  = 1'b1;
        bus.d_req_we     = 1'b0;
        bus.d_req_addr   = 32'h0000_0080;
        for (int g = 0; g < 10; g++) begin
            #1;
            check_output($sformatf("arb_grant%0d", g), {30'd0, bus.d_req_ready, bus.if_req_ready},
                         exp_d[g] ? 32'd2 : 32'd1);
            @(negedge clk);
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            bus.mem_rvalid    = 1'b1;
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
        end
        bus.if_req_valid = 1'b0;
        bus.d_req_valid  = 1'b0;
        #1;
        check_output("arb_d_resp_data", bus.d_resp_data, 32'h1111_2222);

        // Load that memory never answers.
        check_output("pre_timeout_err", timeout_err, 0);
        @(negedge clk);
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 1'b0;
        bus.d_req_addr  = 32'h0000_0300;
        #1;
        check_output("to_ready", bus.d_req_ready, 1);
        @(negedge clk);
        bus.d_req_valid   = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        #1;
        check_output("to_wait_err", timeout_err, 0);
        cycles = 0;
        while (!bus.d_resp_valid && cycles < 20) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check_output("to_cycles", cycles, 8);
        check_output("to_err_set", timeout_err, 1);
        check_output("to_resp_data", bus.d_resp_data, 32'h0);
        check_output("to_busy", busy, 0);
        apply_stimulus(fetch_after, "after_to");
        check_output("to_err_sticky", timeout_err, 1);

        // Reset while waiting, then a stale response.
        @(negedge clk);
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 32'h0000_0500;
        @(negedge clk);
        bus.d_req_valid   = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        #1;
        check_output("rw_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rw_async");
        @(negedge clk);
        rst_n          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        check_output("rw_stale_resp", {30'd0, bus.d_resp_valid, bus.if_resp_valid}, 0);
        check_output("rw_stale_busy", busy, 0);
        check_output("rw_stale_data", bus.d_resp_data, 32'h0);
        apply_stimulus(load_after, "after_rw");

        // Response arriving in the watchdog's final cycle.
        @(negedge clk);
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 32'h0000_0600;
        @(negedge clk);
        bus.d_req_valid   = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        check_output("co_busy", busy, 1);
        check_output("co_no_resp_yet", bus.d_resp_valid, 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h600D_DA7A;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        check_output("co_resp_valid", bus.d_resp_valid, 1);
        check_output("co_resp_data", bus.d_resp_data, 32'h600D_DA7A);
        check_output("co_timeout_err", timeout_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the fetch path (program_counter/instruction_memory side) and the load/store path of the rv32i core.
- One transaction is outstanding at a time; memory response latency is variable.
- Data access has priority, with a bounded streak so fetch cannot starve.
- A watchdog returns a dummy response when the memory never answers.

Parameters:
- MAX_DATA_STREAK, 4: maximum consecutive contended data grants before fetch is forced.
- TIMEOUT, 64: cycles in WAIT before abort; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
if_req_valid  in  1  fetch request
if_req_addr  in  32  fetch byte address
if_req_ready  out  1  fetch request accepted this cycle
if_resp_valid  out  1  fetch response strobe
if_resp_data  out  32  fetched instruction
d_req_valid  in  1  load/store request
d_req_we  in  1  1 = store
d_req_addr  in  32  data byte address
d_req_wdata  in  32  store data
d_req_wstrb  in  4  byte enables for store
d_req_ready  out  1  data request accepted this cycle
d_resp_valid  out  1  data response strobe (load data or store ack)
d_resp_data  out  32  load data; 0 for stores
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  32  latched address
mem_we  out  1  latched write enable (0 for fetch)
mem_wdata  out  32  latched write data
mem_wstrb  out  4  latched strobes (0 for fetch/loads)
mem_rvalid  in  1  memory response/ack
mem_rdata  in  32  memory read data
busy  out  1  state != IDLE
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE, streak=0, owner=fetch, all outputs 0, latched fields 0. Any in-flight transaction is dropped; late mem_rvalid after reset is ignored.
- States: IDLE, ISSUE, WAIT.
- IDLE, arbitration (combinational ready):
  - Only one requester valid: that requester wins.
  - Both valid: data wins unless streak==MAX_DATA_STREAK, in which case fetch wins.
  - Winner's *_req_ready=1; the other requester's ready=0.
  - On the handshake: latch addr/we/wdata/wstrb and owner, then go to ISSUE.
- Streak counter:
  - Data grant while if_req_valid=1: streak+1, saturating at MAX.
  - Any fetch grant: streak=0.
  - Uncontended data grant: streak unchanged.
- ISSUE: mem_req_valid=1 with the latched fields, held stable until mem_req_ready. On mem_req_ready go to WAIT and clear the watchdog count.
- WAIT:
  - mem_req_valid=0.
  - On mem_rvalid: register mem_rdata into the owner's resp_data (0 if store) and go to IDLE.
  - The owner's resp_valid is high for exactly the next cycle.
  - A new request may be accepted in that same cycle.
- Watchdog (TIMEOUT>0):
  - Count cycles in WAIT. When the count reaches TIMEOUT without mem_rvalid: set timeout_err (cleared only by reset), issue owner resp_valid with data 32'h0, go to IDLE.
  - mem_rvalid arriving in the same cycle as expiry wins: normal response, no error.
- mem_rvalid outside WAIT is ignored.
- Minimum latency: handshake cycle 0, mem_req_valid cycle 1 (ready same cycle), rvalid cycle 2, resp_valid cycle 3.
- Non-owner resp_valid is never asserted. resp_data holds its value until the next response to the same owner.

Test Plan:
- Reset then fetch only, addr 0x0000_0010; memory ready at once, rvalid one cycle later with 0x0050_0093 -> if_req_ready pulses at cycle 0, mem_addr=0x10 with mem_we=0, if_resp_valid at cycle 3 with data 0x0050_0093.
- Store addr 0x100, wdata 0xCAFE_F00D, wstrb 4'b0011; memory holds mem_req_ready low for 3 cycles -> mem fields stay stable throughout, d_resp_valid pulses once, d_resp_data=0.
- Both requesters valid continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- TIMEOUT=8, memory never asserts rvalid on a load -> 8 cycles after entering WAIT, timeout_err=1 and d_resp_valid with data 0. A following fetch still completes normally and timeout_err stays 1.
- rst_n asserted while in WAIT, then a stale mem_rvalid arrives after release -> all outputs 0, no resp_valid, state IDLE, next request served normally.
- mem_rvalid coincident with watchdog expiry -> normal response data returned, timeout_err stays 0.
